// File: rtl/spi_mailbox.sv
// Byte mailbox between an SPI slave link and the 68020 bus: SPI bytes queue in an RX FIFO, a bus-written byte is echoed on MISO.
// Optional interrupt output INT2_n is built when SPI_MAILBOX_IRQ_EN is defined.
module spi_mailbox #(
    parameter logic [23:0] BASE_ADDR = 24'hD80000,
    parameter int          DEPTH     = 8
) (
    input  logic        CLKCPU_A,
    input  logic        RESET_n,
    input  logic        AS20,
    input  logic        DS20,
    input  logic        RW,
    input  logic [23:0] A,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    output logic        ACK_n,
    input  logic        SPI_CK,
    input  logic        SPI_NSS,
    input  logic        SPI_MOSI,
    output logic        SPI_MISO
`ifdef SPI_MAILBOX_IRQ_EN
    ,
    output logic        INT2_n
`endif
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    // Stage p0/p1: two-flop synchroniser; p2: history for edge detect.
    // Resetting NSS low means a line already low at reset release never looks like a fresh fall.
    logic sck_p0, sck_p1, sck_p2;
    logic nss_p0, nss_p1, nss_p2;
    logic mosi_p0, mosi_p1;

    always_ff @(posedge CLKCPU_A or negedge RESET_n) begin
        if (!RESET_n) begin
            sck_p0  <= 1'b0;
            sck_p1  <= 1'b0;
            sck_p2  <= 1'b0;
            nss_p0  <= 1'b0;
            nss_p1  <= 1'b0;
            nss_p2  <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sck_p0  <= SPI_CK;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            nss_p0  <= SPI_NSS;
            nss_p1  <= nss_p0;
            nss_p2  <= nss_p1;
            mosi_p0 <= SPI_MOSI;
            mosi_p1 <= mosi_p0;
        end
    end

    logic sck_rise, sck_fall, nss_fall, nss_rise;
    assign sck_rise = sck_p1 & ~sck_p2;
    assign sck_fall = ~sck_p1 & sck_p2;
    assign nss_fall = ~nss_p1 & nss_p2;
    assign nss_rise = nss_p1 & ~nss_p2;

    spi_state_t  spi_state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_in;
    logic [7:0]  shift_out;
    logic        spi_push;
    logic        tx_taken;
    logic [7:0]  tx_byte;
    logic        tx_pending;

    // MISO index 7-bit_cnt: after the wrap bit_cnt is 0, so the reloaded byte's MSB goes out next.
    always_ff @(posedge CLKCPU_A or negedge RESET_n) begin
        if (!RESET_n) begin
            spi_state <= IDLE;
            bit_cnt   <= 3'd0;
            shift_out <= 8'hFF;
            SPI_MISO  <= 1'b1;
            spi_push  <= 1'b0;
            tx_taken  <= 1'b0;
        end else begin
            spi_push <= 1'b0;
            tx_taken <= 1'b0;
            case (spi_state)
                IDLE: begin
                    if (nss_fall) begin
                        spi_state <= SHIFT;
                        bit_cnt   <= 3'd0;
                        shift_out <= tx_byte;
                        SPI_MISO  <= tx_byte[7];
                    end
                end
                SHIFT: begin
                    if (nss_rise) begin
                        spi_state <= IDLE;
                        bit_cnt   <= 3'd0;
                        SPI_MISO  <= 1'b1;
                    end else if (sck_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            spi_push  <= 1'b1;
                            tx_taken  <= 1'b1;
                            shift_out <= tx_byte;
                        end
                    end else if (sck_fall) begin
                        SPI_MISO <= shift_out[3'd7 - bit_cnt];
                    end
                end
                default: spi_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLKCPU_A) begin
        if (spi_state == SHIFT && !nss_rise && sck_rise)
            shift_in <= {shift_in[6:0], mosi_p1};
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic          pop_req, ovf_clr;
    logic          do_pop, do_push;
    logic          rx_nonempty, rx_full;
    logic [7:0]    head;

    assign rx_nonempty = (count != '0);
    assign rx_full     = (count == FULL_CNT);
    assign do_pop      = pop_req && rx_nonempty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign do_push     = spi_push && (!rx_full || do_pop);
    assign head        = rx_nonempty ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge CLKCPU_A) begin
        if (do_push)
            mem[wr_ptr] <= shift_in;
    end

    always_ff @(posedge CLKCPU_A or negedge RESET_n) begin
        if (!RESET_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (spi_push && rx_full && !do_pop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    logic       hit, hit_q, cyc_start;
    logic       ie;
    logic [7:0] status;

    assign hit       = !AS20 && !DS20 && (A[23:1] == BASE_ADDR[23:1]);
    assign cyc_start = hit && !hit_q;
    assign pop_req   = cyc_start && RW && !A[0];
    assign ovf_clr   = cyc_start && !RW && A[0] && D_IN[5];
    assign status    = {rx_nonempty, rx_full, overflow, tx_pending, 3'b000, ie};

    // Every register action is keyed to cyc_start, so a stretched bus cycle acts once.
    always_ff @(posedge CLKCPU_A or negedge RESET_n) begin
        if (!RESET_n) begin
            hit_q      <= 1'b0;
            D_OUT      <= 8'h00;
            D_OE       <= 1'b0;
            ACK_n      <= 1'b1;
            tx_byte    <= 8'hFF;
            tx_pending <= 1'b0;
            ie         <= 1'b0;
        end else begin
            hit_q <= hit;
            D_OE  <= hit && RW;
            if (AS20)
                ACK_n <= 1'b1;
            else if (hit && hit_q)
                ACK_n <= 1'b0;

            if (cyc_start && RW)
                D_OUT <= A[0] ? status : head;

            if (cyc_start && !RW && !A[0]) begin
                tx_byte    <= D_IN;
                tx_pending <= 1'b1;
            end else if (tx_taken) begin
                tx_pending <= 1'b0;
            end

            if (cyc_start && !RW && A[0])
                ie <= D_IN[0];
        end
    end

`ifdef SPI_MAILBOX_IRQ_EN
    always_ff @(posedge CLKCPU_A or negedge RESET_n) begin
        if (!RESET_n)
            INT2_n <= 1'b1;
        else
            INT2_n <= !(ie && rx_nonempty);
    end
`endif

endmodule

// File: tb/tb_spi_mailbox.sv
// Directed plus randomized bench for spi_mailbox against a queue-based mailbox model.
// Checks INT2_n as well when SPI_MAILBOX_IRQ_EN is defined.
module tb_spi_mailbox;

    localparam int          DEPTH = 8;
    localparam logic [23:0] BASE  = 24'hD80000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        as20, ds20, rw;
    logic [23:0] addr;
    logic [7:0]  d_in, d_out;
    logic        d_oe, ack_n;
    logic        spi_ck, spi_nss, spi_mosi, spi_miso;
`ifdef SPI_MAILBOX_IRQ_EN
    logic        int2_n;
`endif

    spi_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .CLKCPU_A (clk),
        .RESET_n  (rst_n),
        .AS20     (as20),
        .DS20     (ds20),
        .RW       (rw),
        .A        (addr),
        .D_IN     (d_in),
        .D_OUT    (d_out),
        .D_OE     (d_oe),
        .ACK_n    (ack_n),
        .SPI_CK   (spi_ck),
        .SPI_NSS  (spi_nss),
        .SPI_MOSI (spi_mosi),
        .SPI_MISO (spi_miso)
`ifdef SPI_MAILBOX_IRQ_EN
        ,
        .INT2_n   (int2_n)
`endif
    );

    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model of the mailbox
    logic [7:0] q[$];
    logic       m_ovf, m_txp, m_ie;
    logic [7:0] m_tx;

    function automatic logic [7:0] m_status();
        return {q.size() != 0, q.size() == DEPTH, m_ovf, m_txp, 3'b000, m_ie};
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_txp = 1'b0;
        m_tx  = 8'hFF;
        m_ie  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic irq_chk(input string tag);
`ifdef SPI_MAILBOX_IRQ_EN
        chk(tag, {7'b0, int2_n}, {7'b0, !(m_ie && q.size() != 0)});
`endif
    endtask

    task automatic bus(input logic r, input logic a0, input logic [7:0] wd,
                       input int hold, output logic [7:0] rd);
        int t;
        @(negedge clk);
        addr = {BASE[23:1], a0};
        rw   = r;
        d_in = wd;
        as20 = 1'b0;
        ds20 = 1'b0;
        t = 0;
        while (ack_n !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ack_assert", {7'b0, ack_n}, 8'h00);
        chk("d_oe_active", {7'b0, d_oe}, {7'b0, r});
        tick(hold);
        rd   = d_out;
        as20 = 1'b1;
        ds20 = 1'b1;
        rw   = 1'b1;
        tick(1);
        chk("ack_release", {7'b0, ack_n}, 8'h01);
        chk("d_oe_idle", {7'b0, d_oe}, 8'h00);
    endtask

    task automatic read_data(input string tag, input int hold);
        logic [7:0] rd, exp;
        bus(1'b1, 1'b0, 8'h00, hold, rd);
        exp = (q.size() != 0) ? q.pop_front() : 8'h00;
        chk(tag, rd, exp);
    endtask

    task automatic read_status(input string tag);
        logic [7:0] rd;
        bus(1'b1, 1'b1, 8'h00, 0, rd);
        chk(tag, rd, m_status());
    endtask

    task automatic write_data(input logic [7:0] b);
        logic [7:0] rd;
        bus(1'b0, 1'b0, b, 0, rd);
        m_tx  = b;
        m_txp = 1'b1;
    endtask

    task automatic write_status(input logic [7:0] b);
        logic [7:0] rd;
        bus(1'b0, 1'b1, b, 0, rd);
        if (b[5])
            m_ovf = 1'b0;
        m_ie = b[0];
    endtask

    task automatic spi_bit(input logic mo, inout logic [7:0] mi);
        spi_mosi = mo;
        tick(4);
        mi = {mi[6:0], spi_miso};
        spi_ck = 1'b1;
        tick(8);
        spi_ck = 1'b0;
        tick(4);
    endtask

    // Master side of one NSS window; a short window models an aborted byte.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits);
        logic [7:0] mi, exp_tx;
        exp_tx = m_tx;
        mi = 8'h00;
        @(negedge clk);
        spi_nss = 1'b0;
        tick(8);
        for (int i = 0; i < nbits; i++)
            spi_bit(mo[7-i], mi);
        tick(4);
        spi_nss  = 1'b1;
        spi_mosi = 1'b0;
        tick(8);
        if (nbits == 8) begin
            chk("miso_byte", mi, exp_tx);
            if (q.size() < DEPTH)
                q.push_back(mo);
            else
                m_ovf = 1'b1;
            m_txp = 1'b0;
        end
        chk("miso_idle", {7'b0, spi_miso}, 8'h01);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mi;
        rst_n    = 1'b0;
        as20     = 1'b1;
        ds20     = 1'b1;
        rw       = 1'b1;
        addr     = 24'h000000;
        d_in     = 8'h00;
        spi_ck   = 1'b0;
        spi_nss  = 1'b1;
        spi_mosi = 1'b0;
        model_reset();
        tick(3);
        chk("rst_d_oe", {7'b0, d_oe}, 8'h00);
        chk("rst_ack_n", {7'b0, ack_n}, 8'h01);
        chk("rst_miso", {7'b0, spi_miso}, 8'h01);
        chk("rst_d_out", d_out, 8'h00);
        rst_n = 1'b1;
        tick(3);
        irq_chk("rst_int2");
        read_status("rst_status");

        spi_xfer(8'hA5, 8);
        read_status("a5_status");
        read_data("a5_data", 0);
        read_status("a5_status_empty");

        write_data(8'h3C);
        read_status("tx_pending_set");
        spi_xfer(8'h00, 8);
        read_status("tx_pending_clr");
        read_data("zero_byte", 0);

        for (int i = 1; i <= DEPTH + 1; i++)
            spi_xfer(i[7:0], 8);
        read_status("ovf_status");
        for (int i = 1; i <= DEPTH; i++)
            read_data("fifo_order", 0);
        read_data("empty_pop", 0);
        write_status(8'h20);
        read_status("ovf_cleared");

        spi_xfer(8'hF0, 5);
        read_status("partial_status");
        spi_xfer(8'h81, 8);
        read_data("after_partial", 0);

        spi_xfer(8'h11, 8);
        spi_xfer(8'h22, 8);
        write_status(8'h01);
        irq_chk("irq_on");
        read_data("long_cycle", 10);
        read_status("long_cycle_one_pop");
        irq_chk("irq_still_on");
        read_data("second_byte", 0);
        irq_chk("irq_off");
        read_status("ie_only");
        write_status(8'h00);

        // Reset in the middle of an SPI byte, then finish the byte with no new NSS fall
        write_data(8'h55);
        spi_xfer(8'h77, 8);
        @(negedge clk);
        spi_nss = 1'b0;
        tick(8);
        mi = 8'h00;
        for (int i = 0; i < 3; i++)
            spi_bit(1'b1, mi);
        rst_n = 1'b0;
        tick(2);
        chk("midrst_miso", {7'b0, spi_miso}, 8'h01);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++)
            spi_bit(1'b1, mi);
        chk("midrst_miso_quiet", {7'b0, spi_miso}, 8'h01);
        tick(4);
        spi_nss = 1'b1;
        tick(8);
        read_status("midrst_status");
        spi_xfer(8'h6E, 8);
        read_data("midrst_next", 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0, 1: spi_xfer(8'($urandom), 8);
                2:    read_data("rnd_data", $urandom_range(0, 3));
                3:    read_status("rnd_status");
                4:    write_data(8'($urandom));
                5:    write_status(8'($urandom));
                default: spi_xfer(8'($urandom), $urandom_range(1, 7));
            endcase
            irq_chk("rnd_int2");
        end
        read_status("final_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
